// File: rtl/reg_wb_unit.sv
// reg_wb_unit: write-side front end of the register file.
// Merges single-cycle ALU results (highest priority, never stalled) with
// data-memory load results (buffered in a circular FIFO, ready/valid) onto
// the single register-file write port, and exports a pending-write mask
// for hazard stalls in the decoder.
//
// Ports:
//   CLK, reset                   clock, synchronous active-high reset
//   alu_valid/alu_waddr/alu_data ALU result (always accepted)
//   ld_valid/ld_waddr/ld_data    load result offer
//   ld_ready                     load can be accepted this cycle
//   write_en/waddr/data_in       registered register-file write port
//   pending_mask                 bit i = uncommitted write to register i
//   fifo_count                   load FIFO occupancy
//   waw_err                      sticky: ALU wrote a register with an older
//                                load still queued for it
module reg_wb_unit #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [D-1:0]               alu_waddr,
  input  logic [W-1:0]               alu_data,
  input  logic                       ld_valid,
  input  logic [D-1:0]               ld_waddr,
  input  logic [W-1:0]               ld_data,
  output logic                       ld_ready,
  output logic                       write_en,
  output logic [D-1:0]               waddr,
  output logic [W-1:0]               data_in,
  output logic [2**D-1:0]            pending_mask,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       waw_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NR = 2**D;

  logic [D-1:0]  q_addr [DEPTH];
  logic [W-1:0]  q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic [NR-1:0] fifo_mask;

  // Backpressure comes only from registered occupancy, so a full FIFO
  // refuses a load even in a cycle where its head is being popped.
  assign ld_ready   = (count < CW'(DEPTH));
  assign accept     = ld_valid && ld_ready;
  assign empty      = (count == '0);
  assign fifo_count = count;

  always_comb begin
    push   = 1'b0;
    pop    = 1'b0;
    bypass = 1'b0;
    if (alu_valid) begin
      push = accept;
    end else if (!empty) begin
      pop  = 1'b1;
      push = accept;
    end else begin
      bypass = accept;
    end
  end

  // An entry is live when its distance from the read pointer is below the
  // occupancy; pointer subtraction wraps because DEPTH is a power of two.
  always_comb begin
    logic [PW-1:0] offs;
    offs      = '0;
    fifo_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if (CW'(offs) < count) fifo_mask[q_addr[i]] = 1'b1;
    end
  end

  assign pending_mask = fifo_mask | (write_en ? (NR'(1) << waddr) : '0);

  // FIFO storage holds no control state, so it is left out of reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_addr[wr_ptr] <= ld_waddr;
      q_data[wr_ptr] <= ld_data;
    end
  end

  // ---- output stage: one edge from source selection to write port ----
  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      data_in  <= '0;
      waw_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      // Only queued loads count: the write stage itself is older than the
      // ALU result and commits first, so it cannot clobber it.
      if (alu_valid && fifo_mask[alu_waddr]) waw_err <= 1'b1;

      if (alu_valid) begin
        write_en <= 1'b1;
        waddr    <= alu_waddr;
        data_in  <= alu_data;
      end else if (pop) begin
        write_en <= 1'b1;
        waddr    <= q_addr[rd_ptr];
        data_in  <= q_data[rd_ptr];
      end else if (bypass) begin
        write_en <= 1'b1;
        waddr    <= ld_waddr;
        data_in  <= ld_data;
      end else begin
        write_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_unit.sv
module tb_reg_wb_unit;

  localparam int W = 8;
  localparam int D = 4;
  localparam int DEPTH = 4;

  logic          CLK;
  logic          reset;
  logic          alu_valid;
  logic [D-1:0]  alu_waddr;
  logic [W-1:0]  alu_data;
  logic          ld_valid;
  logic [D-1:0]  ld_waddr;
  logic [W-1:0]  ld_data;
  logic          ld_ready;
  logic          write_en;
  logic [D-1:0]  waddr;
  logic [W-1:0]  data_in;
  logic [15:0]   pending_mask;
  logic [2:0]    fifo_count;
  logic          waw_err;

  int vectors = 0;
  int errs = 0;

  reg_wb_unit #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_data(ld_data),
    .ld_ready(ld_ready), .write_en(write_en), .waddr(waddr), .data_in(data_in),
    .pending_mask(pending_mask), .fifo_count(fifo_count), .waw_err(waw_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [3:0] a, input logic [7:0] d);
    check({tag, ".we"}, 32'(write_en), 32'(en));
    if (en) begin
      check({tag, ".waddr"}, 32'(waddr), 32'(a));
      check({tag, ".data"}, 32'(data_in), 32'(d));
    end
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_waddr = '0; alu_data = '0;
    ld_valid = 1'b0; ld_waddr = '0; ld_data = '0;
    tick();
    tick();
    check("rst.we", 32'(write_en), 0);
    check("rst.waddr", 32'(waddr), 0);
    check("rst.data", 32'(data_in), 0);
    check("rst.waw", 32'(waw_err), 0);
    reset = 1'b0;

    // Idle for 5 cycles
    for (int k = 0; k < 5; k++) begin
      tick();
      check("idle.we", 32'(write_en), 0);
      check("idle.rdy", 32'(ld_ready), 1);
      check("idle.mask", 32'(pending_mask), 0);
      check("idle.cnt", 32'(fifo_count), 0);
    end

    // Single load bypass r3=0x5A
    ld_valid = 1'b1; ld_waddr = 4'd3; ld_data = 8'h5A;
    tick();
    ld_valid = 1'b0;
    check_wr("byp", 1'b1, 4'd3, 8'h5A);
    check("byp.cnt", 32'(fifo_count), 0);
    check("byp.mask", 32'(pending_mask), 32'h0008);
    tick();
    check("byp.idle", 32'(write_en), 0);
    check("byp.mask0", 32'(pending_mask), 0);

    // Address 0 is writable
    ld_valid = 1'b1; ld_waddr = 4'd0; ld_data = 8'hFF;
    tick();
    ld_valid = 1'b0;
    check_wr("r0", 1'b1, 4'd0, 8'hFF);
    tick();

    // ALU r1 and load r2 in the same cycle
    alu_valid = 1'b1; alu_waddr = 4'd1; alu_data = 8'h11;
    ld_valid = 1'b1; ld_waddr = 4'd2; ld_data = 8'h22;
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    check_wr("dual1", 1'b1, 4'd1, 8'h11);
    check("dual1.cnt", 32'(fifo_count), 1);
    check("dual1.mask", 32'(pending_mask), 32'h0006);
    tick();
    check_wr("dual2", 1'b1, 4'd2, 8'h22);
    check("dual2.cnt", 32'(fifo_count), 0);
    check("dual2.mask", 32'(pending_mask), 32'h0004);
    tick();
    check("dual3.we", 32'(write_en), 0);
    check("dual3.mask", 32'(pending_mask), 0);

    // ALU held 6 cycles, loads r4.. offered with backpressure
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1'b1; alu_waddr = 4'(10 + k); alu_data = 8'(8'hA0 + k);
      ld_valid = 1'b1;
      ld_waddr = 4'(4 + ((k < 4) ? k : 4));
      ld_data  = 8'(8'h44 + ((k < 4) ? k : 4));
      #1;
      check("fill.rdy", 32'(ld_ready), (k < 4) ? 1 : 0);
      tick();
      check_wr("fill.alu", 1'b1, 4'(10 + k), 8'(8'hA0 + k));
      check("fill.cnt", 32'(fifo_count), (k < 3) ? k + 1 : 4);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check("full.rdy", 32'(ld_ready), 0);
    check("full.mask", 32'(pending_mask), 32'h80F0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_wr("drain", 1'b1, 4'(4 + k), 8'(8'h44 + k));
      check("drain.cnt", 32'(fifo_count), 3 - k);
      check("drain.rdy", 32'(ld_ready), 1);
    end
    tick();
    check("drain.end", 32'(write_en), 0);
    check("drain.waw", 32'(waw_err), 0);

    // Load r5 queued behind ALU r9, then ALU writes r5
    alu_valid = 1'b1; alu_waddr = 4'd9; alu_data = 8'h99;
    ld_valid = 1'b1; ld_waddr = 4'd5; ld_data = 8'h55;
    tick();
    ld_valid = 1'b0;
    alu_waddr = 4'd5; alu_data = 8'hE5;
    check("waw.pre", 32'(waw_err), 0);
    check("waw.mask", 32'(pending_mask), 32'h0220);
    tick();
    alu_valid = 1'b0;
    check("waw.set", 32'(waw_err), 1);
    check_wr("waw.alu", 1'b1, 4'd5, 8'hE5);
    tick();
    check_wr("waw.ld", 1'b1, 4'd5, 8'h55);
    check("waw.hold1", 32'(waw_err), 1);
    tick();
    tick();
    check("waw.hold2", 32'(waw_err), 1);

    // Fill 3 entries then reset mid-operation
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_waddr = 4'(12 + k); alu_data = 8'(8'hC0 + k);
      ld_valid = 1'b1; ld_waddr = 4'(1 + k); ld_data = 8'(8'h31 + k);
      tick();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check("pre.cnt", 32'(fifo_count), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst.cnt", 32'(fifo_count), 0);
    check("mrst.mask", 32'(pending_mask), 0);
    check("mrst.we", 32'(write_en), 0);
    check("mrst.waw", 32'(waw_err), 0);
    check("mrst.rdy", 32'(ld_ready), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post.we", 32'(write_en), 0);
      check("post.cnt", 32'(fifo_count), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
